// File: rtl/gbp_update_ctrl_pkg.sv
// gbp_update_ctrl_pkg: predictor update types and sizing helpers shared by the update controller.
package gbp_update_ctrl_pkg;
  localparam int unsigned VLEN = 32;
  localparam int unsigned GBP_IDX_BITS = 8;
  typedef struct packed {
    logic [GBP_IDX_BITS-1:0] index;
  } bp_metadata_t;
  typedef struct packed {
    logic         valid;
    logic         taken;
    bp_metadata_t metadata;
  } bht_prediction_t;
  typedef struct packed {
    logic            valid;
    logic [VLEN-1:0] pc;
    logic            taken;
    bp_metadata_t    metadata;
  } bht_update_t;
  typedef struct packed {
    logic [VLEN-1:0] pc;
    logic            valid;
    logic            taken;
    bp_metadata_t    metadata;
  } gbp_update_ctrl_entry_t;
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/gbp_meta_fifo.sv
// gbp_meta_fifo: flop-based in-order queue of prediction metadata with flush.
module gbp_meta_fifo
  import gbp_update_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned CW = cnt_w(DEPTH)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  gbp_update_ctrl_entry_t push_data_i,
  input  logic                   pop_i,
  output gbp_update_ctrl_entry_t head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [CW-1:0]          count_o
);
  gbp_update_ctrl_entry_t mem_q [DEPTH];
  gbp_update_ctrl_entry_t mem_d [DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign full_o  = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;
  always_comb begin
    mem_d = mem_q;
    if (do_push) mem_d[wr_q] = push_data_i;
    rd_d  = flush_i ? '0 : rd_q + PW'(do_pop);
    wr_d  = flush_i ? '0 : wr_q + PW'(do_push);
    cnt_d = flush_i ? '0 : cnt_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end
  // Contents need no reset: occupancy alone decides what is live.
  always_ff @(posedge clk_i) mem_q <= mem_d;
endmodule

// File: rtl/gbp_update_ctrl.sv
// gbp_update_ctrl: queues consumed predictions and returns a registered update to gbp
// when the oldest branch resolves, flagging mispredicts and protocol errors.
module gbp_update_ctrl
  import gbp_update_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned CW = cnt_w(DEPTH)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_bp_i,
  input  logic            debug_mode_i,
  input  logic            push_valid_i,
  output logic            push_ready_o,
  input  logic [VLEN-1:0] push_pc_i,
  input  bht_prediction_t push_pred_i,
  input  logic            resolve_valid_i,
  input  logic [VLEN-1:0] resolve_pc_i,
  input  logic            resolve_taken_i,
  output bht_update_t     bht_update_o,
  output logic            mispredict_o,
  output logic            pc_mismatch_o,
  output logic            underflow_o,
  output logic [CW-1:0]   count_o
);
  gbp_update_ctrl_entry_t push_entry, head;
  logic full, empty, hit;
  bht_update_t upd_q, upd_d;
  logic mis_q, mis_d, pcm_q, pcm_d, und_q, und_d;
  assign push_entry = '{pc: push_pc_i, valid: push_pred_i.valid, taken: push_pred_i.taken,
                        metadata: push_pred_i.metadata};
  gbp_meta_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_bp_i),
    .push_i      (push_valid_i),
    .push_data_i (push_entry),
    .pop_i       (resolve_valid_i),
    .head_o      (head),
    .full_o      (full),
    .empty_o     (empty),
    .count_o     (count_o)
  );
  assign push_ready_o = !full;
  assign hit = head.pc == resolve_pc_i;
  always_comb begin
    upd_d = '0;
    mis_d = 1'b0;
    pcm_d = 1'b0;
    und_d = 1'b0;
    if (resolve_valid_i && !flush_bp_i) begin
      und_d = empty;
      pcm_d = !empty && !hit;
      if (!empty && hit) begin
        upd_d = '{valid: head.valid && !debug_mode_i, pc: head.pc, taken: resolve_taken_i,
                  metadata: head.metadata};
        mis_d = head.valid && (head.taken != resolve_taken_i);
      end
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      upd_q <= '0;
      mis_q <= 1'b0;
      pcm_q <= 1'b0;
      und_q <= 1'b0;
    end else begin
      upd_q <= upd_d;
      mis_q <= mis_d;
      pcm_q <= pcm_d;
      und_q <= und_d;
    end
  end
  assign bht_update_o  = upd_q;
  assign mispredict_o  = mis_q;
  assign pc_mismatch_o = pcm_q;
  assign underflow_o   = und_q;
endmodule
